// File: rtl/lfsr_pkg.sv
// Shared definitions for the 64-bit Fibonacci LFSR keystream generator and its controller.
package lfsr_pkg;

  localparam int unsigned LFSR_W = 64;

  // Feedback taps (bit positions XORed into the new MSB).
  localparam int unsigned TAP0 = 63;
  localparam int unsigned TAP1 = 3;
  localparam int unsigned TAP2 = 2;
  localparam int unsigned TAP3 = 0;

  typedef enum logic [1:0] {
    StIdle,
    StWarmup,
    StRun
  } ks_state_e;

  // One LFSR step: feedback enters at the MSB, everything shifts toward bit 0.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    logic fb;
    fb = s[TAP0] ^ s[TAP1] ^ s[TAP2] ^ s[TAP3];
    return {fb, s[LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/keystream_ctrl_if.sv
// Seed, enable and keystream handshake bundle; directions are named from the controller's side.
interface keystream_ctrl_if #(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned CNT_W  = 32
);
  logic              i_seed_valid;
  logic [63:0]       i_seed;
  logic              o_seed_ready;
  logic              o_seed_err;
  logic              i_en;
  logic              o_ks_valid;
  logic [WORD_W-1:0] o_ks_data;
  logic              i_ks_ready;
  logic              o_busy;
  logic [CNT_W-1:0]  o_word_cnt;
  logic [63:0]       o_lfsr;

  modport slave (
    input  i_seed_valid, i_seed, i_en, i_ks_ready,
    output o_seed_ready, o_seed_err, o_ks_valid, o_ks_data, o_busy, o_word_cnt, o_lfsr
  );

  modport master (
    output i_seed_valid, i_seed, i_en, i_ks_ready,
    input  o_seed_ready, o_seed_err, o_ks_valid, o_ks_data, o_busy, o_word_cnt, o_lfsr
  );
endinterface

// File: rtl/lfsr64_step.sv
// Combinational single step of the 64-bit keystream LFSR; output bit is s[0] before the shift.
module lfsr64_step
  import lfsr_pkg::*;
(
  input  logic [LFSR_W-1:0] s_i,
  output logic [LFSR_W-1:0] s_next_o,
  output logic              ks_bit_o
);

  assign s_next_o = lfsr_next(s_i);
  assign ks_bit_o = s_i[0];

endmodule

// File: rtl/keystream_ctrl.sv
// Keystream sequencer: seed load with zero-seed rejection, warm-up discard, then serial-to-word
// packing onto a valid/ready stream with backpressure.
module keystream_ctrl
  import lfsr_pkg::*;
#(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned WARMUP = 128,
  parameter int unsigned CNT_W  = 32
) (
  input logic              i_clk,
  input logic              i_reset,
  keystream_ctrl_if.slave  bus
);

  localparam int unsigned IdxW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(WORD_W - 1);

  ks_state_e         state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [31:0]       warm_q, warm_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [WORD_W-1:0] pack_q, pack_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;

  logic [LFSR_W-1:0] lfsr_step;
  logic              ks_bit;
  logic [WORD_W-1:0] word;
  logic              out_fire;
  logic              stall;

  lfsr64_step u_step (
    .s_i      (lfsr_q),
    .s_next_o (lfsr_step),
    .ks_bit_o (ks_bit)
  );

  // Next-state: warm-up/pack progress, output handshake, then seed load which overrides all.
  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    warm_d   = warm_q;
    idx_d    = idx_q;
    pack_d   = pack_q;
    data_d   = data_q;
    valid_d  = valid_q;
    cnt_d    = cnt_q;
    err_d    = 1'b0;
    word     = pack_q;
    out_fire = valid_q && bus.i_ks_ready;
    // Only the word-completing capture has to wait for the output register to drain.
    stall    = (idx_q == IdxLast) && valid_q && !bus.i_ks_ready;

    if (out_fire) begin
      cnt_d   = cnt_q + CNT_W'(1);
      valid_d = 1'b0;
    end

    unique case (state_q)
      StWarmup: begin
        if (bus.i_en) begin
          lfsr_d = lfsr_step;
          warm_d = warm_q + 32'd1;
          if (warm_q + 32'd1 == WARMUP) state_d = StRun;
        end
      end
      StRun: begin
        if (bus.i_en && !stall) begin
          lfsr_d      = lfsr_step;
          word[idx_q] = ks_bit;
          pack_d      = word;
          if (idx_q == IdxLast) begin
            data_d  = word;
            valid_d = 1'b1;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      default: ;
    endcase

    if (bus.i_seed_valid) begin
      if (bus.i_seed == '0) begin
        err_d = 1'b1;
      end else begin
        lfsr_d  = bus.i_seed;
        warm_d  = '0;
        idx_d   = '0;
        valid_d = 1'b0;
        cnt_d   = '0;
        state_d = (WARMUP == 0) ? StRun : StWarmup;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= StIdle;
      lfsr_q  <= '0;
      warm_q  <= '0;
      idx_q   <= '0;
      pack_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      warm_q  <= warm_d;
      idx_q   <= idx_d;
      pack_q  <= pack_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign bus.o_seed_ready = 1'b1;
  assign bus.o_seed_err   = err_q;
  assign bus.o_ks_valid   = valid_q;
  assign bus.o_ks_data    = data_q;
  assign bus.o_busy       = (state_q != StIdle);
  assign bus.o_word_cnt   = cnt_q;
  assign bus.o_lfsr       = lfsr_q;

endmodule

// File: tb/tb_keystream_ctrl.sv
// Bench for keystream_ctrl: two instances (no warm-up / 128-step warm-up), scoreboard queues
// filled from a reference LFSR model, monitors that compare on every output handshake.
module tb_keystream_ctrl;

  localparam int unsigned WW = 8;
  localparam int unsigned CW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;

  keystream_ctrl_if #(.WORD_W(WW), .CNT_W(CW)) ifa ();
  keystream_ctrl_if #(.WORD_W(WW), .CNT_W(CW)) ifb ();

  keystream_ctrl #(.WORD_W(WW), .WARMUP(0), .CNT_W(CW)) u_dut_a (
    .i_clk   (clk),
    .i_reset (rst_a),
    .bus     (ifa.slave)
  );

  keystream_ctrl #(.WORD_W(WW), .WARMUP(128), .CNT_W(CW)) u_dut_b (
    .i_clk   (clk),
    .i_reset (rst_b),
    .bus     (ifb.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference generator.
  function automatic logic [63:0] m_step(input logic [63:0] s);
    return {s[63] ^ s[3] ^ s[2] ^ s[0], s[63:1]};
  endfunction

  function automatic logic [63:0] m_state(input logic [63:0] seed, input int n);
    logic [63:0] s;
    s = seed;
    for (int i = 0; i < n; i++) s = m_step(s);
    return s;
  endfunction

  // Word built from stream bits first..first+7, first bit in bit 0.
  function automatic logic [7:0] m_word(input logic [63:0] seed, input int first);
    logic [63:0] s;
    logic [7:0]  w;
    s = m_state(seed, first);
    for (int i = 0; i < 8; i++) begin
      w[i] = s[0];
      s    = m_step(s);
    end
    return w;
  endfunction

  task automatic push_b(input logic [63:0] seed, input int warm, input int n);
    exp_b.delete();
    for (int w = 0; w < n; w++) exp_b.push_back(m_word(seed, warm + 8 * w));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor A: compares only the hand-computed words queued for it.
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst_a && ifa.o_ks_valid && ifa.i_ks_ready && exp_a.size() > 0) begin
      e = exp_a.pop_front();
      check("a_word", 64'(ifa.o_ks_data), 64'(e));
    end
  end

  // Monitor B: every accepted word must match the next queued model word.
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst_b && ifb.o_ks_valid && ifb.i_ks_ready) begin
      if (exp_b.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL b_word: got unexpected word %h, expected none", ifb.o_ks_data);
      end else begin
        e = exp_b.pop_front();
        check("b_word", 64'(ifb.o_ks_data), 64'(e));
      end
    end
  end

  initial begin
    logic [63:0] seed_b, seed_c, seed_d;
    logic [7:0]  w0;
    int          edges;
    int          bad;

    seed_b = 64'hDEADBEEF_01234567;
    seed_c = 64'h0123_4567_89AB_CDEF;
    seed_d = 64'h0000_0000_0000_00A5;

    ifa.i_seed_valid = 1'b0; ifa.i_seed = '0; ifa.i_en = 1'b1; ifa.i_ks_ready = 1'b1;
    ifb.i_seed_valid = 1'b0; ifb.i_seed = '0; ifb.i_en = 1'b1; ifb.i_ks_ready = 1'b0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    tick();
    tick();
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Reset state.
    check("rst_seed_ready", 64'(ifb.o_seed_ready), 64'd1);
    check("rst_ks_valid",   64'(ifb.o_ks_valid),   64'd0);
    check("rst_busy",       64'(ifb.o_busy),       64'd0);
    check("rst_word_cnt",   64'(ifb.o_word_cnt),   64'd0);
    check("rst_lfsr",       ifb.o_lfsr,            64'd0);
    check("rst_err",        64'(ifb.o_seed_err),   64'd0);

    // Instance A: WARMUP=0, seed 1.
    exp_a.push_back(8'h01);
    for (int i = 0; i < 6; i++) exp_a.push_back(8'h00);
    ifa.i_seed = 64'h1;
    ifa.i_seed_valid = 1'b1;
    tick();
    ifa.i_seed_valid = 1'b0;
    edges = 1;
    while (!ifa.o_ks_valid && edges < 50) begin
      tick();
      edges++;
    end
    check("a_latency", 64'(edges), 64'd9);
    check("a_lfsr_8steps", ifa.o_lfsr, 64'hFF00_0000_0000_0000);
    check("a_busy", 64'(ifa.o_busy), 64'd1);
    edges = 0;
    while (exp_a.size() > 0 && edges < 200) begin
      tick();
      edges++;
    end
    check("a_words_drained", 64'(exp_a.size()), 64'd0);
    check("a_word_cnt", 64'(ifa.o_word_cnt), 64'd7);
    ifa.i_ks_ready = 1'b0;
    rst_a = 1'b1;

    // Instance B: zero seed while idle.
    ifb.i_seed = '0;
    ifb.i_seed_valid = 1'b1;
    tick();
    ifb.i_seed_valid = 1'b0;
    check("b_zero_err",   64'(ifb.o_seed_err), 64'd1);
    check("b_zero_busy",  64'(ifb.o_busy),     64'd0);
    check("b_zero_lfsr",  ifb.o_lfsr,          64'd0);
    check("b_zero_valid", 64'(ifb.o_ks_valid), 64'd0);
    tick();
    check("b_zero_err_pulse", 64'(ifb.o_seed_err), 64'd0);

    // Seed with warm-up, consumer stalled from the start.
    push_b(seed_b, 128, 40);
    w0 = m_word(seed_b, 128);
    ifb.i_seed = seed_b;
    ifb.i_seed_valid = 1'b1;
    tick();
    ifb.i_seed_valid = 1'b0;
    check("b_load_lfsr", ifb.o_lfsr, seed_b);
    edges = 1;
    while (!ifb.o_ks_valid && edges < 400) begin
      tick();
      edges++;
    end
    check("b_latency", 64'(edges), 64'd137);
    check("b_first_word", 64'(ifb.o_ks_data), 64'(w0));

    bad = 0;
    repeat (40) begin
      tick();
      if (ifb.o_ks_data !== w0 || ifb.o_ks_valid !== 1'b1) bad++;
    end
    check("b_hold_stable", 64'(bad), 64'd0);
    check("b_lfsr_frozen", ifb.o_lfsr, m_state(seed_b, 143));

    // Zero seed during the stall changes nothing but the error pulse.
    ifb.i_seed = '0;
    ifb.i_seed_valid = 1'b1;
    tick();
    ifb.i_seed_valid = 1'b0;
    check("b_stall_zero_err",   64'(ifb.o_seed_err), 64'd1);
    check("b_stall_zero_busy",  64'(ifb.o_busy),     64'd1);
    check("b_stall_zero_valid", 64'(ifb.o_ks_valid), 64'd1);
    check("b_stall_zero_data",  64'(ifb.o_ks_data),  64'(w0));
    check("b_stall_zero_lfsr",  ifb.o_lfsr,          m_state(seed_b, 143));
    check("b_stall_zero_cnt",   64'(ifb.o_word_cnt), 64'd0);

    // Release: next word follows one cycle after the accept.
    ifb.i_ks_ready = 1'b1;
    tick();
    check("b_release_valid", 64'(ifb.o_ks_valid), 64'd1);
    check("b_release_data",  64'(ifb.o_ks_data),  64'(m_word(seed_b, 136)));
    check("b_release_cnt",   64'(ifb.o_word_cnt), 64'd1);
    edges = 0;
    while (ifb.o_word_cnt != 4 && edges < 200) begin
      tick();
      edges++;
    end
    check("b_run_cnt", 64'(ifb.o_word_cnt), 64'd4);

    // Rekey in the same cycle as an output accept.
    edges = 0;
    while (!ifb.o_ks_valid && edges < 50) begin
      tick();
      edges++;
    end
    check("b_rekey_pre_valid", 64'(ifb.o_ks_valid), 64'd1);
    ifb.i_seed = seed_c;
    ifb.i_seed_valid = 1'b1;
    tick();
    ifb.i_seed_valid = 1'b0;
    push_b(seed_c, 128, 40);
    check("b_rekey_valid", 64'(ifb.o_ks_valid), 64'd0);
    check("b_rekey_cnt",   64'(ifb.o_word_cnt), 64'd0);
    check("b_rekey_lfsr",  ifb.o_lfsr,          seed_c);
    edges = 1;
    while (!ifb.o_ks_valid && edges < 400) begin
      tick();
      edges++;
    end
    check("b_rekey_latency", 64'(edges), 64'd137);
    edges = 0;
    while (ifb.o_word_cnt != 3 && edges < 200) begin
      tick();
      edges++;
    end
    check("b_rekey_cnt_run", 64'(ifb.o_word_cnt), 64'd3);

    // Enable toggling every cycle: steps only on odd cycles after the load.
    ifb.i_seed = seed_d;
    ifb.i_seed_valid = 1'b1;
    ifb.i_en = 1'b0;
    tick();
    ifb.i_seed_valid = 1'b0;
    push_b(seed_d, 128, 40);
    ifb.i_en = 1'b1;
    edges = 1;
    while (!ifb.o_ks_valid && edges < 800) begin
      tick();
      edges++;
      ifb.i_en = ~ifb.i_en;
    end
    check("b_en_latency", 64'(edges), 64'd272);
    bad = 0;
    while (ifb.o_word_cnt != 3 && bad < 400) begin
      tick();
      bad++;
      ifb.i_en = ~ifb.i_en;
    end
    check("b_en_cnt", 64'(ifb.o_word_cnt), 64'd3);
    repeat (3) begin
      tick();
      ifb.i_en = ~ifb.i_en;
    end

    // Reset mid-RUN.
    check("b_pre_reset_busy", 64'(ifb.o_busy), 64'd1);
    rst_b = 1'b1;
    tick();
    check("b_reset_valid", 64'(ifb.o_ks_valid),   64'd0);
    check("b_reset_data",  64'(ifb.o_ks_data),    64'd0);
    check("b_reset_busy",  64'(ifb.o_busy),       64'd0);
    check("b_reset_cnt",   64'(ifb.o_word_cnt),   64'd0);
    check("b_reset_lfsr",  ifb.o_lfsr,            64'd0);
    check("b_reset_err",   64'(ifb.o_seed_err),   64'd0);
    check("b_reset_ready", 64'(ifb.o_seed_ready), 64'd1);
    rst_b = 1'b0;
    ifb.i_en = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
